// File: rtl/axis_frame_tag_inserter.sv
// Store-and-forward byte-stream tagger: buffers one frame, then replays it wrapped in an optional LE length header and LE timestamp footer.
// Latency: tlast accepted at edge N -> first output byte valid after edge N+1; one byte per cycle after that, with no bubbles.
// Backpressure: input is stalled for the whole replay; output data/last are held while m_axis_tready is low.
//
// Ports: clk/rstn (async active-low) | timestamp: free-running time, latched at first byte
//        s_axis_*: byte-wide input stream | m_axis_*: byte-wide tagged output stream
//        frame_dropped: one-cycle pulse per oversize frame discarded
module axis_frame_tag_inserter #(
  parameter int MAX_FRAME_BYTES            = 1600,
  parameter int ENABLE_FRAME_LENGTH_HEADER = 1,
  parameter int ENABLE_TIMESTAMP_FOOTER    = 1,
  parameter int FRAME_LENGTH_WIDTH         = 16,
  parameter int TIMESTAMP_WIDTH            = 72
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       frame_dropped
);

  localparam int CNT_W   = $clog2(MAX_FRAME_BYTES + 1);
  localparam int AW      = $clog2(MAX_FRAME_BYTES);
  localparam int HB      = FRAME_LENGTH_WIDTH / 8;
  localparam int FB      = TIMESTAMP_WIDTH / 8;
  localparam int SEG_MAX = (HB > FB) ? HB : FB;
  localparam int SEG_W   = $clog2(SEG_MAX + 1);
  localparam bit HDR_EN  = (ENABLE_FRAME_LENGTH_HEADER != 0);
  localparam bit FTR_EN  = (ENABLE_TIMESTAMP_FOOTER != 0);

  typedef enum logic [2:0] {RECV, SEND_HDR, SEND_FRAME, SEND_FTR, DROP} state_t;

  state_t                     r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_wr_cnt, r_len, r_frm_idx;
  logic [SEG_W-1:0]           r_seg;
  logic [FRAME_LENGTH_WIDTH-1:0] r_hdr_sr;
  logic [TIMESTAMP_WIDTH-1:0] r_ts_sr;
  logic                       r_all_loaded, r_s_rdy, r_drop;
  logic                       r_m_vld, r_m_last;
  logic [7:0]                 r_m_dat, r_mem_q;
  logic [7:0]                 r_mem [0:MAX_FRAME_BYTES-1];

  logic w_in_recv, w_s_hs, w_m_hs, w_final_hs, w_at_max, w_wr_en, w_load, w_last_frm;
  logic w_ld_last, w_seg_inc, w_seg_clr, w_frm_adv, w_drop_set, w_wr_clr;
  logic [7:0]       w_ld_dat;
  logic [CNT_W-1:0] w_len_nxt, w_rd_idx;
  logic [AW-1:0]    w_rd_addr;
  logic [FRAME_LENGTH_WIDTH-1:0] w_len_trunc;

  assign w_in_recv     = (r_state == RECV) || (r_state == DROP);
  // r_s_rdy lags the state by one cycle, giving the one dead cycle after reset and after each replay.
  assign s_axis_tready = r_s_rdy && w_in_recv;
  assign w_s_hs        = s_axis_tvalid && s_axis_tready;
  assign w_m_hs        = r_m_vld && m_axis_tready;
  assign w_final_hs    = w_m_hs && r_m_last;
  assign w_at_max      = (r_wr_cnt == CNT_W'(MAX_FRAME_BYTES));
  assign w_wr_en       = (r_state == RECV) && w_s_hs && !w_at_max;
  assign w_len_nxt     = r_wr_cnt + CNT_W'(1);
  assign w_last_frm    = (r_frm_idx == r_len - CNT_W'(1));
  // The output register is refilled whenever it is empty or being drained this cycle.
  assign w_load        = !w_in_recv && !r_all_loaded && (!r_m_vld || m_axis_tready);

  assign m_axis_tdata  = r_m_dat;
  assign m_axis_tvalid = r_m_vld;
  assign m_axis_tlast  = r_m_last;
  assign frame_dropped = r_drop;

  generate
    if (FRAME_LENGTH_WIDTH > CNT_W) begin : g_len_ext
      assign w_len_trunc = {{(FRAME_LENGTH_WIDTH-CNT_W){1'b0}}, w_len_nxt};
    end else if (FRAME_LENGTH_WIDTH == CNT_W) begin : g_len_eq
      assign w_len_trunc = w_len_nxt;
    end else begin : g_len_cut
      assign w_len_trunc = w_len_nxt[FRAME_LENGTH_WIDTH-1:0];
    end
  endgenerate

  // Read address runs one ahead of consumption so r_mem_q always holds the next frame byte.
  assign w_rd_idx  = r_frm_idx + (w_frm_adv ? CNT_W'(1) : CNT_W'(0));
  assign w_rd_addr = (w_rd_idx < CNT_W'(MAX_FRAME_BYTES)) ? w_rd_idx[AW-1:0] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= RECV;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_dat    = 8'h00;
    w_ld_last   = 1'b0;
    w_seg_inc   = 1'b0;
    w_seg_clr   = 1'b0;
    w_frm_adv   = 1'b0;
    w_drop_set  = 1'b0;
    w_wr_clr    = 1'b0;
    case (r_state)
      RECV: begin
        if (w_s_hs) begin
          if (w_at_max) begin
            if (s_axis_tlast) begin
              w_drop_set = 1'b1;
              w_wr_clr   = 1'b1;
            end else begin
              w_state_nxt = DROP;
            end
          end else if (s_axis_tlast) begin
            w_state_nxt = HDR_EN ? SEND_HDR : SEND_FRAME;
          end
        end
      end
      DROP: begin
        if (w_s_hs && s_axis_tlast) begin
          w_drop_set  = 1'b1;
          w_wr_clr    = 1'b1;
          w_state_nxt = RECV;
        end
      end
      SEND_HDR: begin
        w_ld_dat = r_hdr_sr[7:0];
        if (w_load) begin
          if (r_seg == SEG_W'(HB - 1)) begin
            w_seg_clr   = 1'b1;
            w_state_nxt = SEND_FRAME;
          end else begin
            w_seg_inc = 1'b1;
          end
        end
      end
      SEND_FRAME: begin
        w_ld_dat = r_mem_q;
        if (w_load) begin
          w_frm_adv = 1'b1;
          if (w_last_frm) begin
            if (FTR_EN) w_state_nxt = SEND_FTR;
            else        w_ld_last   = 1'b1;
          end
        end
      end
      SEND_FTR: begin
        w_ld_dat = r_ts_sr[7:0];
        if (w_load) begin
          if (r_seg == SEG_W'(FB - 1)) w_ld_last = 1'b1;
          else                          w_seg_inc = 1'b1;
        end
      end
      default: w_state_nxt = RECV;
    endcase
    if (w_final_hs) w_state_nxt = RECV;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_cnt     <= '0;
      r_len        <= '0;
      r_frm_idx    <= '0;
      r_seg        <= '0;
      r_hdr_sr     <= '0;
      r_ts_sr      <= '0;
      r_all_loaded <= 1'b0;
      r_s_rdy      <= 1'b0;
      r_drop       <= 1'b0;
      r_m_vld      <= 1'b0;
      r_m_last     <= 1'b0;
      r_m_dat      <= 8'h00;
    end else begin
      r_s_rdy <= w_in_recv;
      r_drop  <= w_drop_set;

      if (w_final_hs || w_wr_clr) r_wr_cnt <= '0;
      else if (w_wr_en)           r_wr_cnt <= w_len_nxt;

      if (w_wr_en && s_axis_tlast) r_len <= w_len_nxt;

      if (w_wr_en && s_axis_tlast)                     r_hdr_sr <= w_len_trunc;
      else if ((r_state == SEND_HDR) && w_load)        r_hdr_sr <= r_hdr_sr >> 8;

      if ((r_state == RECV) && w_s_hs && (r_wr_cnt == '0)) r_ts_sr <= timestamp;
      else if ((r_state == SEND_FTR) && w_load)            r_ts_sr <= r_ts_sr >> 8;

      if (r_state == RECV) r_frm_idx <= '0;
      else if (w_frm_adv)  r_frm_idx <= r_frm_idx + CNT_W'(1);

      if ((r_state == RECV) || w_seg_clr) r_seg <= '0;
      else if (w_seg_inc)                 r_seg <= r_seg + SEG_W'(1);

      if (w_final_hs)                  r_all_loaded <= 1'b0;
      else if (w_load && w_ld_last)    r_all_loaded <= 1'b1;

      if (w_load) begin
        r_m_vld  <= 1'b1;
        r_m_dat  <= w_ld_dat;
        r_m_last <= w_ld_last;
      end else if (w_m_hs) begin
        r_m_vld  <= 1'b0;
        r_m_last <= 1'b0;
      end
    end
  end

  // Frame buffer with registered read. While receiving, byte 0 is captured directly so a
  // one-byte frame is ready for replay without an extra read cycle.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_cnt[AW-1:0]] <= s_axis_tdata;
    if (r_state == RECV) begin
      if (w_s_hs && (r_wr_cnt == '0)) r_mem_q <= s_axis_tdata;
    end else begin
      r_mem_q <= r_mem[w_rd_addr];
    end
  end

endmodule

// File: doc/axis_frame_tag_inserter.md
# axis_frame_tag_inserter

Store-and-forward AXI4-Stream frame tagger that sits between the MAC receive path and the switch fabric. It buffers one byte-wide Ethernet frame and then re-emits it. It can prepend a little-endian frame-length header and append a little-endian timestamp footer. This produces exactly the stream format our byte-stream checkers consume with header/footer enabled.

## Interface
Parameters:
- MAX_FRAME_BYTES, 1600: frame buffer depth in bytes; longer frames are dropped.
- ENABLE_FRAME_LENGTH_HEADER, 1: nonzero prepends the length header.
- ENABLE_TIMESTAMP_FOOTER, 1: nonzero appends the timestamp footer.
- FRAME_LENGTH_WIDTH, 16: header width in bits; multiple of 8.
- TIMESTAMP_WIDTH, 72: footer width in bits; multiple of 8.

Ports:
- clk  in  1  sole clock.
- rstn  in  1  asynchronous, active-low reset.
- timestamp  in  TIMESTAMP_WIDTH  free-running time value, synchronous to clk.
- s_axis_tdata  in  8  input frame byte.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last byte of frame.
- m_axis_tdata  out  8  output byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last byte of tagged frame.
- frame_dropped  out  1  one-cycle pulse per dropped (oversize) frame.

## Operation
- States: RECV, SEND_HDR, SEND_FRAME, SEND_FTR, DROP.
- **RECV**
  - s_axis_tready=1, m_axis_tvalid=0.
  - Each handshake writes the byte to mem[wr_cnt] and increments wr_cnt.
  - On the first handshake of a frame (wr_cnt==0), the `timestamp` input is latched.
  - On a tlast handshake:
    - Latch len = wr_cnt+1.
    - Go to SEND_HDR if the header is enabled, else SEND_FRAME.
  - If wr_cnt==MAX_FRAME_BYTES and a non-tlast byte handshakes: go to DROP.
  - If wr_cnt==MAX_FRAME_BYTES and the byte carries tlast: pulse frame_dropped and stay in RECV with wr_cnt=0.
- **SEND_HDR**
  - Emits FRAME_LENGTH_WIDTH/8 bytes of len, LSB byte first.
  - len is truncated to FRAME_LENGTH_WIDTH.
  - len counts Ethernet bytes only, excluding header and footer.
- **SEND_FRAME**
  - Emits mem[0..len-1] in order.
- **SEND_FTR**
  - Emits TIMESTAMP_WIDTH/8 bytes of the latched timestamp, LSB byte first.
- **Exit from sending:** after the final output handshake, go to RECV with wr_cnt=0.
- **m_axis_tlast:** asserted only on the final byte.
  - The final byte is the last footer byte if the footer is enabled, otherwise the last frame byte.
- **s_axis_tready in send states:** 0. Exactly one frame is in flight.
- **DROP**
  - s_axis_tready=1; bytes are discarded.
  - On the tlast handshake: frame_dropped=1 for one cycle, then RECV with wr_cnt=0.
  - Nothing is emitted on m_axis for a dropped frame.
- **Both options disabled:** the block is a pure store-and-forward buffer.

## Timing
- **Reset values:**
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_dropped=0.
  - State=RECV, wr_cnt=0.
- **First cycle after reset release:** s_axis_tready=1.
- **Reset asserted mid-operation:** all outputs clear immediately; the buffered frame and latched values are discarded.
- **Start latency:** tlast accepted at edge N → m_axis_tvalid=1 after edge N+1.
- **Throughput:** with m_axis_tready held high, one byte per cycle with no bubbles.
  - This holds across the header→frame and frame→footer boundaries.
  - Memory read latency must be hidden by prefetch.
- **Backpressure:**
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast are held stable.
  - m_axis_tvalid never deasserts before the handshake.
- **Return to receive:** final m_axis handshake at edge M → s_axis_tready=1 after edge M+1.
- **frame_dropped:** asserted for the cycle following the tlast handshake in DROP.
- **Timestamp sampling:** the value present at the first-byte handshake edge.
  - The latched value is unaffected by later changes to `timestamp`.
- **Counter widths:** wr_cnt is wide enough to hold MAX_FRAME_BYTES with no wrap.

## Test plan
- **Nominal frame:** 60-byte frame 0x00..0x3B, timestamp=0x0123456789ABCDEF00 at the first byte.
  - Expect 71 bytes out: 0x3C, 0x00, then 0x00..0x3B, then 0x00, 0xEF, 0xCD, 0xAB, 0x89, 0x67, 0x45, 0x23, 0x01.
  - tlast only on byte 71.
  - Output is gap-free with m_axis_tready=1.
- **Backpressure:** same frame with random 0–3 cycle stalls on m_axis_tready.
  - Identical byte sequence; data stable during every stall.
  - s_axis_tready=0 throughout sending.
- **Oversize drop (MAX_FRAME_BYTES=64):**
  - A 100-byte frame produces exactly one frame_dropped pulse and no m_axis output.
  - The following 10-byte frame is emitted correctly: header 0x0A, 0x00.
- **Minimum frame:** a 1-byte frame 0xA5 → 0x01, 0x00, 0xA5, then 9 timestamp bytes.
  - Two back-to-back 1-byte frames both emit correctly.
- **Options off:**
  - Header disabled: output starts directly with frame bytes.
  - Footer disabled: tlast on the last frame byte.
  - Both disabled: output equals input.
- **Reset mid-send:** assert rstn=0 during SEND_FRAME byte 20.
  - m_axis_tvalid=0 immediately.
  - After release the stale frame is never emitted, and the next frame is correct.
